code_stream_checker: RTL and testbench



---
 rtl/code_stream_checker.sv | 72 +++++++
 tb/tb_code_stream_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/code_stream_checker.sv
// code_stream_checker: locks onto x[n]=x[n-1]+x[n-2] on the Slt-selected stream, flags violations, counts samples/errors
module code_stream_checker #(
  parameter int W        = 64,
  parameter int MAX_MISS = 2,
  parameter int CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Slt,
  input  logic [W-1:0]     Input0,
  input  logic [W-1:0]     Input1,
  output logic             Locked,
  output logic             Match,
  output logic             Err,
  output logic [CNT_W-1:0] SampleCnt,
  output logic [15:0]      ErrCnt,
  output logic [W-1:0]     Last
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEED  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  logic [1:0]   state;
  logic [W-1:0] a, b, s, sum;
  logic [3:0]   miss;
  logic         slt_q, slt_chg, hit, lose;
  assign s       = Slt ? Input1 : Input0;
  assign sum     = a + b;
  assign hit     = s == sum;
  assign slt_chg = (state != IDLE) && (Slt != slt_q);
  assign lose    = (miss + 4'd1) == 4'(MAX_MISS);
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      Last      <= '0;
      SampleCnt <= '0;
      ErrCnt    <= '0;
      miss      <= '0;
      slt_q     <= 1'b0;
      Locked    <= 1'b0;
      Match     <= 1'b0;
      Err       <= 1'b0;
    end else begin
      Locked <= state == CHECK;
      Match  <= 1'b0;
      Err    <= 1'b0;
      if (En) begin
        SampleCnt <= SampleCnt + CNT_W'(1);
        Last      <= s;
        slt_q     <= Slt;
        if (state == IDLE || slt_chg) begin
          a     <= s;
          miss  <= '0;
          state <= SEED;
        end else if (state == SEED) begin
          b     <= s;
          state <= CHECK;
        end else begin
          a     <= b;
          b     <= s;
          Match <= hit;
          Err   <= !hit;
          miss  <= (hit || lose) ? 4'd0 : miss + 4'd1;
          if (!hit && ErrCnt != 16'hFFFF) ErrCnt <= ErrCnt + 16'd1;
          if (!hit && lose) state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_code_stream_checker.sv
// tb_code_stream_checker: random + directed stimulus checked each cycle against a behavioural model
module tb_code_stream_checker;
  localparam int W = 64;
  logic Clk = 0, Reset = 0, En = 0, Slt = 0;
  logic [W-1:0] Input0 = '0, Input1 = '0;
  logic [1:0] locked, match, err;
  logic [31:0] scnt[2];
  logic [15:0] ecnt[2];
  logic [W-1:0] last[2];
  int checks = 0, failures = 0;
  always #5 Clk = ~Clk;
  code_stream_checker #(.W(W), .MAX_MISS(2), .CNT_W(32)) u0 (
    .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Input0(Input0), .Input1(Input1),
    .Locked(locked[0]), .Match(match[0]), .Err(err[0]), .SampleCnt(scnt[0]), .ErrCnt(ecnt[0]), .Last(last[0]));
  code_stream_checker #(.W(W), .MAX_MISS(15), .CNT_W(32)) u1 (
    .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Input0(Input0), .Input1(Input1),
    .Locked(locked[1]), .Match(match[1]), .Err(err[1]), .SampleCnt(scnt[1]), .ErrCnt(ecnt[1]), .Last(last[1]));
  int m_seeds[2], m_miss[2], m_ecnt[2];
  logic [W-1:0] m_a[2], m_b[2], m_last[2], ms, msum;
  logic [31:0] m_cnt[2];
  logic m_slt[2], e_locked[2], e_match[2], e_err[2];
  bit armed = 0;
  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      if (failures <= 30) $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask
  always @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      e_match[i] = 0;
      e_err[i] = 0;
      if (!Reset) begin
        m_seeds[i] = 0; m_miss[i] = 0; m_ecnt[i] = 0; m_a[i] = '0; m_b[i] = '0;
        m_last[i] = '0; m_cnt[i] = '0; m_slt[i] = 0; e_locked[i] = 0;
        armed = 1;
      end else begin
        e_locked[i] = m_seeds[i] == 2;
        if (En) begin
          ms = Slt ? Input1 : Input0;
          m_cnt[i]++;
          m_last[i] = ms;
          if (m_seeds[i] == 0 || Slt != m_slt[i]) begin
            m_a[i] = ms; m_seeds[i] = 1; m_miss[i] = 0;
          end else if (m_seeds[i] == 1) begin
            m_b[i] = ms; m_seeds[i] = 2;
          end else begin
            msum = m_a[i] + m_b[i];
            if (ms == msum) begin
              e_match[i] = 1; m_miss[i] = 0;
            end else begin
              e_err[i] = 1;
              if (m_ecnt[i] < 65535) m_ecnt[i]++;
              m_miss[i]++;
              if (m_miss[i] == (i ? 15 : 2)) begin m_seeds[i] = 0; m_miss[i] = 0; end
            end
            m_a[i] = m_b[i];
            m_b[i] = ms;
          end
          m_slt[i] = Slt;
        end
      end
    end
  end
  always @(negedge Clk) if (armed) for (int i = 0; i < 2; i++) begin
    cmp($sformatf("u%0d.Locked", i), 64'(locked[i]), 64'(e_locked[i]));
    cmp($sformatf("u%0d.Match", i), 64'(match[i]), 64'(e_match[i]));
    cmp($sformatf("u%0d.Err", i), 64'(err[i]), 64'(e_err[i]));
    cmp($sformatf("u%0d.SampleCnt", i), 64'(scnt[i]), 64'(m_cnt[i]));
    cmp($sformatf("u%0d.ErrCnt", i), 64'(ecnt[i]), 64'(m_ecnt[i]));
    cmp($sformatf("u%0d.Last", i), last[i], m_last[i]);
  end
  task automatic step(input bit en, input bit slt, input logic [W-1:0] v);
    En = en;
    Slt = slt;
    if (slt) begin Input1 = v; Input0 = {$urandom, $urandom}; end
    else begin Input0 = v; Input1 = {$urandom, $urandom}; end
    @(posedge Clk); #1;
  endtask
  task automatic do_reset();
    Reset = 0;
    step(0, 0, '0);
    Reset = 1;
  endtask
  task automatic all_zero(input string nm);
    cmp({nm, ".Locked"}, 64'(locked[0]), 0);
    cmp({nm, ".Match"}, 64'(match[0]), 0);
    cmp({nm, ".Err"}, 64'(err[0]), 0);
    cmp({nm, ".SampleCnt"}, 64'(scnt[0]), 0);
    cmp({nm, ".ErrCnt"}, 64'(ecnt[0]), 0);
    cmp({nm, ".Last"}, last[0], 0);
  endtask
  initial begin
    logic [W-1:0] ta, tb, nx, v;
    int errs, n;
    bit bad;
    Reset = 0; En = 1; Input0 = 64'd5;
    repeat (2) begin @(posedge Clk); #1; end
    all_zero("reset");
    Reset = 1;
    step(1, 0, 0);
    step(1, 0, 1); cmp("lock_not_yet", 64'(locked[0]), 0);
    step(1, 0, 1); cmp("lock_third", 64'(locked[0]), 1); cmp("match_1", 64'(match[0]), 1);
    step(1, 0, 2); cmp("match_2", 64'(match[0]), 1);
    step(1, 0, 3); cmp("match_3", 64'(match[0]), 1);
    step(1, 0, 5); cmp("match_5", 64'(match[0]), 1);
    cmp("cnt6", 64'(scnt[0]), 6); cmp("last5", last[0], 5); cmp("ecnt0", 64'(ecnt[0]), 0);
    step(1, 0, 9); cmp("err_9", 64'(err[0]), 1); cmp("nomatch_9", 64'(match[0]), 0);
    step(1, 0, 13); cmp("err_13", 64'(err[0]), 1); cmp("ecnt2", 64'(ecnt[0]), 2);
    step(1, 0, 21); cmp("unlocked", 64'(locked[0]), 0); cmp("noerr_21", 64'(err[0]), 0);
    step(1, 0, 34); cmp("noerr_34", 64'(err[0]), 0);
    step(1, 0, 55); cmp("match_55", 64'(match[0]), 1); cmp("ecnt2_hold", 64'(ecnt[0]), 2);
    do_reset();
    step(1, 0, 64'h8000_0000_0000_0000);
    step(1, 0, 64'h8000_0000_0000_0000);
    step(1, 0, 0); cmp("wrap_0", 64'(match[0]), 1);
    step(1, 0, 64'h8000_0000_0000_0000); cmp("wrap_8", 64'(match[0]), 1);
    step(1, 1, 7); cmp("sel_noerr", 64'(err[0]), 0); cmp("sel_nomatch", 64'(match[0]), 0);
    step(1, 1, 11); cmp("sel_seed", 64'(locked[0]), 0); cmp("sel_11", 64'(match[0]), 0);
    step(1, 1, 18); cmp("sel_match", 64'(match[0]), 1);
    do_reset();
    step(1, 0, 0);
    repeat (3) begin
      step(0, 0, {$urandom, $urandom});
      cmp("gap_match", 64'(match[0]), 0); cmp("gap_err", 64'(err[0]), 0);
    end
    step(1, 0, 1);
    step(1, 0, 1); cmp("gap_hit", 64'(match[0]), 1); cmp("gap_cnt", 64'(scnt[0]), 3);
    Reset = 0;
    step(1, 0, 2);
    all_zero("midreset");
    Reset = 1;
    for (int k = 0; k < 3000; k++) begin
      Reset = $urandom_range(0, 299) != 0;
      if ($urandom_range(0, 15) == 0) Slt = ~Slt;
      n = $urandom_range(0, 9);
      v = n < 7 ? m_a[0] + m_b[0] : n < 9 ? {$urandom, $urandom} : '0;
      step($urandom_range(0, 3) != 0, Slt, v);
    end
    Reset = 1;
    do_reset();
    step(1, 0, 0);
    step(1, 0, 1);
    ta = 0; tb = 1; errs = 0; n = 0;
    while (!(errs >= 65540 && n % 15 == 0)) begin
      bad = (n % 15) != 14;
      nx = ta + tb + (bad ? 64'd1 : 64'd0);
      step(1, 0, nx);
      ta = tb; tb = nx;
      if (bad) errs++;
      n++;
    end
    step(1, 0, ta + tb + 64'd1);
    cmp("sat_err", 64'(err[1]), 1);
    cmp("sat_ecnt", 64'(ecnt[1]), 64'hFFFF);
    cmp("sat_locked", 64'(locked[1]), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
